// File: rtl/eva_intr_ctrl_if.sv
// Event delivery handshake between eva_intr_ctrl (master) and its consumer (slave).
interface eva_intr_ctrl_if #(
  parameter int unsigned INTR_NUM = 32
);
  logic                evt_valid;
  logic                evt_ready;
  logic [INTR_NUM-1:0] evt_vec;

  modport master (
    output evt_valid,
    output evt_vec,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_vec,
    output evt_ready
  );
endinterface

// File: rtl/eva_intr_ctrl.sv
// Interrupt collector: per-channel edge/level capture into a pending register, delivered as
// snapshots over a valid/ready handshake. Overflow flags are built only with EVA_INTR_OVF_EN.
module eva_intr_ctrl #(
  parameter int unsigned INTR_NUM = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INTR_NUM-1:0] interrupt,
  input  logic [INTR_NUM-1:0] intr_mask,
  input  logic [INTR_NUM-1:0] intr_level,
  output logic [INTR_NUM-1:0] pend,
  output logic [INTR_NUM-1:0] ovf,
  eva_intr_ctrl_if.master     evt_if
);

  typedef enum logic {StIdle, StPresent} state_e;

  state_e              state_q;
  logic                evt_valid_q;
  logic [INTR_NUM-1:0] evt_vec_q;
  logic [INTR_NUM-1:0] intr_q;
  logic                armed_q;
  logic [INTR_NUM-1:0] pend_q, pend_d;
  logic [INTR_NUM-1:0] rise, set, clr;

  // No edge may be seen on the first edge after reset: lines already high are not rises.
  assign rise = interrupt & ~intr_q & {INTR_NUM{armed_q}};
  assign set  = ((intr_level & interrupt) | (~intr_level & rise)) & ~intr_mask;
  assign clr  = (evt_valid_q && evt_if.evt_ready) ? evt_vec_q : '0;

  always_comb begin
    pend_d = (pend_q & ~clr) | set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_q  <= '0;
      armed_q <= 1'b0;
      pend_q  <= '0;
    end else begin
      intr_q  <= interrupt;
      armed_q <= 1'b1;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      evt_valid_q <= 1'b0;
      evt_vec_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|pend_q) begin
            evt_vec_q   <= pend_q;
            evt_valid_q <= 1'b1;
            state_q     <= StPresent;
          end
        end
        StPresent: begin
          if (evt_if.evt_ready) begin
            evt_vec_q   <= '0;
            evt_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
      endcase
    end
  end

`ifdef EVA_INTR_OVF_EN
  logic [INTR_NUM-1:0] ovf_q, ovf_d;

  // A new set on a still-pending, not-being-delivered bit means an event was lost.
  always_comb begin
    ovf_d = (ovf_q & ~(clr & ~set)) | (set & pend_q & ~clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = '0;
`endif

  assign pend             = pend_q;
  assign evt_if.evt_valid = evt_valid_q;
  assign evt_if.evt_vec   = evt_vec_q;

endmodule

// File: tb/tb_eva_intr_ctrl.sv
// Directed bench for eva_intr_ctrl: delivery latency, backpressure, level redelivery,
// set-vs-clear collision, overflow flags and asynchronous reset.
module tb_eva_intr_ctrl;
  localparam int unsigned N = 32;
`ifdef EVA_INTR_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] interrupt, intr_mask, intr_level, pend, ovf;
  int           n_checks = 0;
  int           n_pass   = 0;

  eva_intr_ctrl_if #(.INTR_NUM(N)) evt_if ();

  eva_intr_ctrl #(.INTR_NUM(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .interrupt  (interrupt),
    .intr_mask  (intr_mask),
    .intr_level (intr_level),
    .pend       (pend),
    .ovf        (ovf),
    .evt_if     (evt_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    interrupt = '0;
    intr_mask = '0;
    intr_level = '0;
    evt_if.evt_ready = 1'b0;
    #22;
    chk("rst_valid", 64'(evt_if.evt_valid), 64'h0);
    chk("rst_vec", 64'(evt_if.evt_vec), 64'h0);
    chk("rst_pend", 64'(pend), 64'h0);
    chk("rst_ovf", 64'(ovf), 64'h0);
    rst_n = 1'b1;
    tick();

    // Single-cycle edge pulse, consumer always ready
    evt_if.evt_ready = 1'b1;
    interrupt = 32'h8;
    tick();
    interrupt = '0;
    chk("a_pend_k", 64'(pend), 64'h8);
    chk("a_valid_k", 64'(evt_if.evt_valid), 64'h0);
    tick();
    chk("a_valid_k1", 64'(evt_if.evt_valid), 64'h1);
    chk("a_vec_k1", 64'(evt_if.evt_vec), 64'h8);
    tick();
    chk("a_pend_k2", 64'(pend), 64'h0);
    chk("a_valid_k2", 64'(evt_if.evt_valid), 64'h0);
    chk("a_vec_k2", 64'(evt_if.evt_vec), 64'h0);

    // Backpressure: bit 0 held in evt_vec, bit 5 waits for the next pass
    evt_if.evt_ready = 1'b0;
    interrupt = 32'h1;
    tick();
    interrupt = '0;
    tick();
    chk("b_vec_first", 64'(evt_if.evt_vec), 64'h1);
    interrupt = 32'h20;
    tick();
    interrupt = '0;
    chk("b_pend_both", 64'(pend), 64'h21);
    chk("b_vec_held", 64'(evt_if.evt_vec), 64'h1);
    tick();
    chk("b_vec_held2", 64'(evt_if.evt_vec), 64'h1);
    chk("b_valid_held", 64'(evt_if.evt_valid), 64'h1);
    evt_if.evt_ready = 1'b1;
    tick();
    chk("b_idle_valid", 64'(evt_if.evt_valid), 64'h0);
    chk("b_idle_vec", 64'(evt_if.evt_vec), 64'h0);
    chk("b_idle_pend", 64'(pend), 64'h20);
    tick();
    chk("b_second_valid", 64'(evt_if.evt_valid), 64'h1);
    chk("b_second_vec", 64'(evt_if.evt_vec), 64'h20);
    tick();
    chk("b_drain_pend", 64'(pend), 64'h0);

    // Level channel 7 held high: redelivered every second cycle until masked
    intr_level = 32'h80;
    interrupt = 32'h80;
    tick();
    chk("c_pend", 64'(pend), 64'h80);
    tick();
    chk("c_vec1", 64'(evt_if.evt_vec), 64'h80);
    tick();
    chk("c_gap_valid", 64'(evt_if.evt_valid), 64'h0);
    chk("c_reset_pend", 64'(pend), 64'h80);
    tick();
    chk("c_vec2", 64'(evt_if.evt_vec), 64'h80);
    intr_mask = 32'h80;
    tick();
    tick();
    chk("c_masked_valid", 64'(evt_if.evt_valid), 64'h0);
    chk("c_masked_pend", 64'(pend), 64'h0);
    interrupt = '0;
    intr_mask = '0;
    intr_level = '0;
    tick();

    // Edge on bit 2 in the very cycle evt_vec=0x4 is accepted
    evt_if.evt_ready = 1'b0;
    interrupt = 32'h4;
    tick();
    interrupt = '0;
    tick();
    chk("d_vec", 64'(evt_if.evt_vec), 64'h4);
    evt_if.evt_ready = 1'b1;
    interrupt = 32'h4;
    tick();
    interrupt = '0;
    chk("d_pend_kept", 64'(pend), 64'h4);
    chk("d_ovf", 64'(ovf), 64'h0);
    tick();
    chk("d_redeliver", 64'(evt_if.evt_vec), 64'h4);
    tick();
    chk("d_drain", 64'(pend), 64'h0);

    // Second edge on bit 1 while undelivered sets overflow; accept clears it
    evt_if.evt_ready = 1'b0;
    interrupt = 32'h2;
    tick();
    interrupt = '0;
    tick();
    interrupt = 32'h2;
    tick();
    interrupt = '0;
    chk("e_ovf_set", 64'(ovf), OvfEn ? 64'h2 : 64'h0);
    chk("e_pend", 64'(pend), 64'h2);
    evt_if.evt_ready = 1'b1;
    tick();
    chk("e_ovf_clr", 64'(ovf), 64'h0);
    chk("e_pend_clr", 64'(pend), 64'h0);
    evt_if.evt_ready = 1'b0;

    // Asynchronous reset in PRESENT with evt_vec=0xFF; mask must not clear pending bit 0
    interrupt = 32'hFF;
    tick();
    interrupt = '0;
    tick();
    chk("f_vec", 64'(evt_if.evt_vec), 64'hFF);
    intr_mask = 32'h1;
    interrupt = 32'hFF;
    tick();
    chk("f_pend_masked", 64'(pend), 64'hFF);
    chk("f_ovf", 64'(ovf), OvfEn ? 64'hFE : 64'h0);
    interrupt = 32'h3;
    intr_level = 32'h2;
    intr_mask = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("f_rst_valid", 64'(evt_if.evt_valid), 64'h0);
    chk("f_rst_vec", 64'(evt_if.evt_vec), 64'h0);
    chk("f_rst_pend", 64'(pend), 64'h0);
    chk("f_rst_ovf", 64'(ovf), 64'h0);
    #2;
    rst_n = 1'b1;

    // Lines high at reset release: edge bit 0 ignored, level bit 1 sets
    tick();
    chk("g_pend_first", 64'(pend), 64'h2);
    tick();
    chk("g_pend_next", 64'(pend), 64'h2);
    chk("g_vec", 64'(evt_if.evt_vec), 64'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eva_intr_ctrl.md
EVA_INTR_CTRL -- requirements
Module: eva_intr_ctrl

Interface
REQ-001 SHALL provide parameter INTR_NUM, default 32, number of interrupt channels, legal range 1..64.
REQ-002 SHALL provide port clk  input  1  single clock for all logic.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port interrupt  input  INTR_NUM  raw interrupt lines, synchronous to clk.
REQ-005 SHALL provide port intr_mask  input  INTR_NUM  1 = channel masked (no new pending).
REQ-006 SHALL provide port intr_level  input  INTR_NUM  1 = level mode, 0 = rising-edge mode, per channel.
REQ-007 SHALL provide port evt_valid  output  1  event vector available.
REQ-008 SHALL provide port evt_ready  input  1  consumer accepts event vector.
REQ-009 SHALL provide port evt_vec  output  INTR_NUM  delivered pending snapshot.
REQ-010 SHALL provide port pend  output  INTR_NUM  live pending register.
REQ-011 SHALL provide port ovf  output  INTR_NUM  sticky per-channel overflow flags.

Function
REQ-012 SHALL register interrupt into intr_ff every clk; rise = interrupt & ~intr_ff.
REQ-013 SHALL form set = ((intr_level & interrupt) | (~intr_level & rise)) & ~intr_mask, combinationally.
REQ-014 SHALL form clr = evt_vec when evt_valid & evt_ready, else 0.
REQ-015 SHALL update pend <= (pend & ~clr) | set each cycle; set wins over clr on the same bit.
REQ-016 SHALL NOT clear already-pending bits when intr_mask asserts; masking only blocks new sets.
REQ-017 SHALL implement two states: IDLE and PRESENT.
REQ-018 SHALL, in IDLE with pend != 0, load evt_vec <= pend, assert evt_valid, and move to PRESENT on the next edge.
REQ-019 SHALL, in PRESENT, hold evt_valid = 1 and evt_vec stable until evt_ready = 1; then return to IDLE with evt_valid = 0 for at least one cycle.
REQ-020 SHALL ignore evt_ready while evt_valid = 0.
REQ-021 SHALL give latency: edge-mode rise sampled at posedge k -> pend bit 1 after k -> evt_valid 1 after k+1.
REQ-022 SHALL exclude from evt_vec any bits set while in PRESENT; those bits are delivered in the next IDLE->PRESENT pass.
REQ-023 SHALL, for a level-mode channel still high at accept, re-set pend the same cycle so the channel is delivered again.
REQ-024 SHALL keep evt_vec = 0 whenever in IDLE.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear intr_ff, pend, evt_vec, ovf, evt_valid and force state IDLE, including mid-PRESENT.
REQ-026 SHALL treat interrupt lines already high at reset release as no edge (intr_ff captured from the first post-reset edge); level-mode channels set pend normally.

Configuration
REQ-027 SHALL compile overflow tracking only when macro EVA_INTR_OVF_EN is defined.
REQ-028 SHALL, with EVA_INTR_OVF_EN, set ovf[i] when set[i] & pend[i] & ~clr[i], and clear ovf[i] when clr[i] & ~set[i]; set wins.
REQ-029 SHALL, without EVA_INTR_OVF_EN, tie ovf to 0 and instantiate no overflow flops; all other behaviour is unchanged.

Verification
REQ-030 SHALL cover: INTR_NUM=32, all edge mode, evt_ready=1, pulse interrupt[3] for 1 cycle at posedge 10 -> pend=0x8 after 10, evt_valid=1 and evt_vec=0x8 after 11, pend=0 after 12.
REQ-031 SHALL cover: evt_ready=0, pulse bits 0 then 5 two cycles apart -> evt_vec=0x1 held; then evt_ready=1 -> next delivery evt_vec=0x20 after one idle cycle.
REQ-032 SHALL cover: intr_level[7]=1, interrupt[7] held high, evt_ready=1 -> evt_vec=0x80 delivered every 2 cycles until the line drops; intr_mask[7]=1 stops new deliveries.
REQ-033 SHALL cover: edge on bit 2 in the accept cycle of evt_vec=0x4 -> pend[2] stays 1 and is redelivered; with EVA_INTR_OVF_EN, ovf[2] stays 0.
REQ-034 SHALL cover: with EVA_INTR_OVF_EN, two edges on bit 1 while evt_ready=0 -> ovf=0x2; accept -> ovf=0; without the macro, ovf=0 throughout.
REQ-035 SHALL cover: rst_n low during PRESENT with evt_vec=0xFF -> evt_valid, evt_vec, pend and ovf all 0 immediately, without waiting for a clk edge.
